// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3-256 absorb controller.
package sha3_pkg;

  localparam int         RATE_LANES = 17;
  localparam int         LANE_W     = 64;
  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_END    = 8'h80;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WAIT_MSG   = 4'd1,
    ABSORB     = 4'd2,
    PAD_LANE   = 4'd3,
    PAD_FINAL  = 4'd4,
    PERM_START = 4'd5,
    PERM_FINAL = 4'd6,
    PERM_WAIT  = 4'd7,
    DONE       = 4'd8
  } state_t;

  // Number of valid bytes in a beat; TKEEP is expected to be contiguous from bit 0.
  function automatic logic [3:0] keep_to_count(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + 4'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sha3_absorb_ctrl_if.sv
// AXI-Stream message input of the absorb controller.
interface sha3_absorb_ctrl_if;

  logic [sha3_pkg::LANE_W-1:0] S_TDATA;
  logic                        S_TVALID;
  logic                        S_TREADY;
  logic                        S_TLAST;
  logic [7:0]                  S_TKEEP;

  modport master (
    output S_TDATA,
    output S_TVALID,
    output S_TLAST,
    output S_TKEEP,
    input  S_TREADY
  );

  modport slave (
    input  S_TDATA,
    input  S_TVALID,
    input  S_TLAST,
    input  S_TKEEP,
    output S_TREADY
  );

endinterface

// File: rtl/sha3_pad_merge.sv
// Builds the lane word for one message beat: drops non-kept bytes and, on the
// final beat, ORs in the domain byte and (on the last rate lane) the end bit.
module sha3_pad_merge
  import sha3_pkg::*;
(
  input  logic [LANE_W-1:0] tdata_i,
  input  logic [7:0]        tkeep_i,
  input  logic              last_i,
  input  logic              last_lane_i,
  output logic [LANE_W-1:0] lane_o
);

  logic [3:0] keep_cnt_s;
  logic       partial_last_s;

  assign keep_cnt_s     = keep_to_count(tkeep_i);
  assign partial_last_s = last_i && (keep_cnt_s != 4'd8);

  // Byte-wise mask plus padding; the domain byte lands right after the last kept byte.
  always_comb begin
    lane_o = '0;
    for (int b = 0; b < 8; b++) begin
      lane_o[8*b +: 8] = (tdata_i[8*b +: 8] & {8{tkeep_i[b]}})
                       | ((partial_last_s && (keep_cnt_s == 4'(b))) ? PAD_DOMAIN : 8'h00);
    end
    lane_o[LANE_W-1 -: 8] = lane_o[LANE_W-1 -: 8]
                          | ((partial_last_s && last_lane_i) ? PAD_END : 8'h00);
  end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// SHA3-256 absorb sequencer: XORs stream beats into the rate lanes, pads the
// message and launches one Keccak permutation per 1088-bit block.
module sha3_absorb_ctrl #(
  parameter int DATA_WIDTH = sha3_pkg::LANE_W,
  parameter int RATE_LANES = sha3_pkg::RATE_LANES,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  sha3_absorb_ctrl_if.slave     s_axis,
  output logic                  state_clear,
  output logic                  lane_we,
  output logic [4:0]            lane_idx,
  output logic [DATA_WIDTH-1:0] lane_data,
  output logic                  perm_start,
  input  logic                  perm_done,
  output logic                  hash_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  block_cnt
);

  import sha3_pkg::*;

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

  state_t                state_q, state_d;
  logic [4:0]            lane_cnt_q, lane_cnt_d;
  logic [4:0]            pad_lane_q, pad_lane_d;
  logic                  pad_pending_q, pad_pending_d;
  logic                  final_q, final_d;
  logic [CNT_WIDTH-1:0]  block_cnt_q, block_cnt_d;

  logic                  state_clear_q, state_clear_d;
  logic                  lane_we_q, lane_we_d;
  logic [4:0]            lane_idx_q, lane_idx_d;
  logic [DATA_WIDTH-1:0] lane_data_q, lane_data_d;
  logic                  perm_start_q, perm_start_d;
  logic                  hash_done_q, hash_done_d;
  logic                  busy_q, busy_d;
  logic                  tready_q, tready_d;

  logic                  hs_s;
  logic                  last_lane_s;
  logic                  full_keep_s;
  logic [3:0]            keep_cnt_s;
  logic [LANE_W-1:0]     merged_s;
  logic [CNT_WIDTH-1:0]  block_cnt_inc_s;

  assign hs_s            = s_axis.S_TVALID && tready_q;
  assign last_lane_s     = (lane_cnt_q == LAST_LANE);
  assign keep_cnt_s      = keep_to_count(s_axis.S_TKEEP);
  assign full_keep_s     = (keep_cnt_s == 4'd8);
  assign block_cnt_inc_s = (block_cnt_q == {CNT_WIDTH{1'b1}}) ? block_cnt_q
                                                              : block_cnt_q + CNT_WIDTH'(1);

  sha3_pad_merge u_pad_merge (
    .tdata_i     (s_axis.S_TDATA),
    .tkeep_i     (s_axis.S_TKEEP),
    .last_i      (s_axis.S_TLAST),
    .last_lane_i (last_lane_s),
    .lane_o      (merged_s)
  );

  // State and output registers; reset aborts any message in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= IDLE;
      lane_cnt_q    <= 5'd0;
      pad_lane_q    <= 5'd0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
      block_cnt_q   <= '0;
      state_clear_q <= 1'b0;
      lane_we_q     <= 1'b0;
      lane_idx_q    <= 5'd0;
      lane_data_q   <= '0;
      perm_start_q  <= 1'b0;
      hash_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      tready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_cnt_q    <= lane_cnt_d;
      pad_lane_q    <= pad_lane_d;
      pad_pending_q <= pad_pending_d;
      final_q       <= final_d;
      block_cnt_q   <= block_cnt_d;
      state_clear_q <= state_clear_d;
      lane_we_q     <= lane_we_d;
      lane_idx_q    <= lane_idx_d;
      lane_data_q   <= lane_data_d;
      perm_start_q  <= perm_start_d;
      hash_done_q   <= hash_done_d;
      busy_q        <= busy_d;
      tready_q      <= tready_d;
    end
  end

  // Next-state and bookkeeping (lane counter, pad lane, pending flags, block count).
  always_comb begin
    state_d       = state_q;
    lane_cnt_d    = lane_cnt_q;
    pad_lane_d    = pad_lane_q;
    pad_pending_d = pad_pending_q;
    final_d       = final_q;
    block_cnt_d   = block_cnt_q;
    case (state_q)
      IDLE: begin
        lane_cnt_d    = 5'd0;
        pad_lane_d    = 5'd0;
        pad_pending_d = 1'b0;
        final_d       = 1'b0;
        block_cnt_d   = '0;
        state_d       = WAIT_MSG;
      end
      WAIT_MSG, ABSORB: begin
        if (!hs_s) begin
          state_d = state_q;
        end else if (!s_axis.S_TLAST) begin
          if (last_lane_s) begin
            lane_cnt_d = 5'd0;
            state_d    = PERM_START;
          end else begin
            lane_cnt_d = lane_cnt_q + 5'd1;
            state_d    = ABSORB;
          end
        end else if (!full_keep_s) begin
          lane_cnt_d = 5'd0;
          state_d    = last_lane_s ? PERM_FINAL : PAD_FINAL;
        end else if (last_lane_s) begin
          // Full final lane: the domain byte has to go into a fresh block.
          lane_cnt_d    = 5'd0;
          pad_pending_d = 1'b1;
          state_d       = PERM_START;
        end else begin
          pad_lane_d = lane_cnt_q + 5'd1;
          lane_cnt_d = 5'd0;
          state_d    = PAD_LANE;
        end
      end
      PAD_LANE: begin
        pad_pending_d = 1'b0;
        state_d       = (pad_lane_q == LAST_LANE) ? PERM_FINAL : PAD_FINAL;
      end
      PAD_FINAL: begin
        state_d = PERM_FINAL;
      end
      PERM_START: begin
        block_cnt_d = block_cnt_inc_s;
        state_d     = PERM_WAIT;
      end
      PERM_FINAL: begin
        block_cnt_d = block_cnt_inc_s;
        final_d     = 1'b1;
        state_d     = PERM_WAIT;
      end
      PERM_WAIT: begin
        if (!perm_done) begin
          state_d = PERM_WAIT;
        end else if (final_q) begin
          state_d = DONE;
        end else if (pad_pending_q) begin
          pad_lane_d = 5'd0;
          state_d    = PAD_LANE;
        end else begin
          state_d = ABSORB;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; everything is registered, so ready/busy follow the next state.
  always_comb begin
    state_clear_d = 1'b0;
    lane_we_d     = 1'b0;
    lane_idx_d    = 5'd0;
    lane_data_d   = '0;
    perm_start_d  = 1'b0;
    hash_done_d   = 1'b0;
    tready_d      = (state_d == WAIT_MSG) || (state_d == ABSORB);
    busy_d        = !((state_d == IDLE) || (state_d == WAIT_MSG));
    case (state_q)
      IDLE: begin
        state_clear_d = 1'b1;
      end
      WAIT_MSG, ABSORB: begin
        if (hs_s) begin
          lane_we_d   = 1'b1;
          lane_idx_d  = lane_cnt_q;
          lane_data_d = merged_s;
        end else begin
          lane_we_d = 1'b0;
        end
      end
      PAD_LANE: begin
        lane_we_d   = 1'b1;
        lane_idx_d  = pad_lane_q;
        lane_data_d = (pad_lane_q == LAST_LANE) ? {PAD_END, 48'h0, PAD_DOMAIN}
                                                : {56'h0, PAD_DOMAIN};
      end
      PAD_FINAL: begin
        lane_we_d   = 1'b1;
        lane_idx_d  = LAST_LANE;
        lane_data_d = {PAD_END, 56'h0};
      end
      PERM_START, PERM_FINAL: begin
        perm_start_d = 1'b1;
      end
      DONE: begin
        hash_done_d = 1'b1;
      end
      default: begin
        lane_we_d = 1'b0;
      end
    endcase
  end

  assign s_axis.S_TREADY = tready_q;
  assign state_clear     = state_clear_q;
  assign lane_we         = lane_we_q;
  assign lane_idx        = lane_idx_q;
  assign lane_data       = lane_data_q;
  assign perm_start      = perm_start_q;
  assign hash_done       = hash_done_q;
  assign busy            = busy_q;
  assign block_cnt       = block_cnt_q;

endmodule

// File: doc/sha3_absorb_ctrl.md
Name: sha3_absorb_ctrl

Overview:
- Sequences the SHA3-256 absorb phase between the AXI-Stream input and the Keccak permutation core.
- Accepts 64-bit message beats and XORs them lane-by-lane into the rate portion of the state: 17 lanes, 1088 bits.
- Inserts SHA3 padding (0x06 … 0x80) on TLAST and launches one permutation per full rate block.
- Signals hash_done once the final permutation completes, so the squeeze logic can read the digest.

Parameters:
- DATA_WIDTH, 64: stream beat width, equal to one Keccak lane.
- RATE_LANES, 17: lanes per rate block (1088/64).
- CNT_WIDTH, 16: width of the block counter.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; asynchronous, active-high.
- S_TDATA  in  64  message beat; byte 0 is the first message byte.
- S_TVALID  in  1  beat valid.
- S_TREADY  out  1  beat accepted when S_TVALID && S_TREADY.
- S_TLAST  in  1  final beat of the message.
- S_TKEEP  in  8  byte enables; contiguous from bit 0; nonzero.
- state_clear  out  1  one-cycle pulse that zeroes the Keccak state.
- lane_we  out  1  XOR lane_data into lane lane_idx.
- lane_idx  out  5  target lane, 0..RATE_LANES-1.
- lane_data  out  64  value to XOR into the lane.
- perm_start  out  1  one-cycle pulse that starts a permutation.
- perm_done  in  1  one-cycle pulse when the permutation completes.
- hash_done  out  1  one-cycle pulse; digest valid in the core.
- busy  out  1  high in every state except IDLE and WAIT_MSG.
- block_cnt  out  CNT_WIDTH  permutations issued for the current message; saturates.

Behaviour:
- Reset values: all outputs 0; state = IDLE; lane counter = 0; block_cnt = 0.
- ARESET asserted mid-operation aborts immediately. Any in-flight perm_done is ignored after reset.
- IDLE:
  - pulse state_clear for one cycle.
  - clear lane counter and block_cnt.
  - go to WAIT_MSG.
- WAIT_MSG:
  - S_TREADY = 1.
  - On handshake, process the beat exactly as in ABSORB (below) and go to ABSORB.
- ABSORB:
  - S_TREADY = 1.
  - On each handshake, in the next cycle: lane_we = 1, lane_idx = lane counter, lane_data = S_TDATA with non-kept bytes forced to 0. Latency is 1 cycle.
  - Non-last beat, lane counter < 16: increment lane counter.
  - Non-last beat, lane counter = 16: go to PERM_START; lane counter returns to 0.
- Last beat, k = popcount(S_TKEEP) < 8:
  - lane_data byte k is ORed with 0x06.
  - If lane counter = 16, byte 7 is additionally ORed with 0x80, then go to PERM_FINAL.
  - Otherwise go to PAD_FINAL.
- Last beat, k = 8, lane counter < 16: go to PAD_LANE with pad lane = lane counter + 1.
- Last beat, k = 8, lane counter = 16: go to PERM_START with flag pad_pending = 1.
  - After perm_done, go to PAD_LANE with pad lane = 0.
- PAD_LANE:
  - lane_we, lane_idx = pad lane, lane_data = 0x06.
  - If pad lane = 16, lane_data = 0x8000_0000_0000_0006 and go to PERM_FINAL.
  - Otherwise go to PAD_FINAL.
- PAD_FINAL: lane_we, lane_idx = 16, lane_data = 0x8000_0000_0000_0000; go to PERM_FINAL.
- PERM_START / PERM_FINAL:
  - pulse perm_start; increment block_cnt (saturating); go to PERM_WAIT.
  - S_TREADY = 0 from the cycle after the triggering handshake until perm_done.
- PERM_WAIT:
  - Hold until perm_done.
  - Then go to ABSORB for a mid-message block, to PAD_LANE if pad_pending, or to DONE for the final block.
- DONE: pulse hash_done; go to IDLE. The next message starts after state_clear.
- At most one lane_we per cycle. lane_we is never asserted while in PERM_WAIT.
- S_TREADY is registered; it drops at most one cycle late, and no beat is accepted while lane_we would collide with a pad write.
- TKEEP = 0 or non-contiguous: undefined input; the implementation treats k as popcount.

Decomposition:
- Package sha3_pkg:
  - state enum: IDLE, WAIT_MSG, ABSORB, PAD_LANE, PAD_FINAL, PERM_START, PERM_FINAL, PERM_WAIT, DONE.
  - constants RATE_LANES, LANE_W, PAD_DOMAIN = 8'h06, PAD_END = 8'h80.
  - function keep_to_count.
- One sub-module, sha3_pad_merge: combinational; inputs TDATA, TKEEP, last, last-lane flag; output is the masked and padded lane word.

Test Plan:
- Empty-ish message, 1 beat TDATA = 0x..41, TKEEP = 0x01, TLAST -> lane0 = 0x0641, lane16 = 0x8000000000000000, one perm_start, hash_done, block_cnt = 1.
- 8-byte message, TKEEP = 0xFF, TLAST -> lane0 = TDATA, PAD_LANE writes lane1 = 0x06, lane16 = 0x80<<56, block_cnt = 1.
- 17 full beats with the last beat carrying TLAST -> perm after lane16, then lane0 = 0x06, lane16 = 0x80<<56, second perm, block_cnt = 2.
- 17 beats with the last beat TKEEP = 0x7F -> lane16 = data | 0x06<<56 | 0x80<<56 (byte7 = 0x86), single perm.
- 20-beat message with TVALID gaps and perm_done delayed 30 cycles -> S_TREADY low during PERM_WAIT, no lost or duplicated beats, lane_idx resumes at 0.
- ARESET pulsed mid-ABSORB (lane 5) -> all outputs 0 immediately; state_clear pulses after release; next message hashes correctly.
